// File: rtl/execute_cycle_if.sv
// EX-stage bundle: ID/EX inputs, forwarding selects,
// branch redirect and EX/MEM register outputs.
interface execute_cycle_if #(
    parameter int XLEN = 32
);
    // ID/EX control
    logic            regwritee;
    logic            alusrce;
    logic            memwritee;
    logic            resultsrce;
    logic            branche;
    logic [2:0]      alucontrole;
    // ID/EX data
    logic [XLEN-1:0] rd1_e;
    logic [XLEN-1:0] rd2_e;
    logic [XLEN-1:0] imm_ext_e;
    logic [4:0]      rd_e;
    logic [XLEN-1:0] pce;
    logic [XLEN-1:0] pcplus4e;
    // forwarding
    logic [XLEN-1:0] resultw;
    logic [1:0]      forwarda_e;
    logic [1:0]      forwardb_e;
    // branch redirect to fetch
    logic            pcsrce;
    logic [XLEN-1:0] pctargete;
    // EX/MEM register
    logic            regwritem;
    logic            memwritem;
    logic            resultsrcm;
    logic [4:0]      rd_m;
    logic [XLEN-1:0] pcplus4m;
    logic [XLEN-1:0] writedatam;
    logic [XLEN-1:0] aluresultm;

    modport master (
        output regwritee, alusrce, memwritee, resultsrce,
        output branche, alucontrole,
        output rd1_e, rd2_e, imm_ext_e, rd_e, pce, pcplus4e,
        output resultw, forwarda_e, forwardb_e,
        input  pcsrce, pctargete,
        input  regwritem, memwritem, resultsrcm, rd_m,
        input  pcplus4m, writedatam, aluresultm
    );

    modport slave (
        input  regwritee, alusrce, memwritee, resultsrce,
        input  branche, alucontrole,
        input  rd1_e, rd2_e, imm_ext_e, rd_e, pce, pcplus4e,
        input  resultw, forwarda_e, forwardb_e,
        output pcsrce, pctargete,
        output regwritem, memwritem, resultsrcm, rd_m,
        output pcplus4m, writedatam, aluresultm
    );
endinterface

// File: rtl/execute_cycle.sv
// Execute stage: forwarding muxes, ALU, beq resolution,
// branch target and the EX/MEM pipeline register.
module execute_cycle #(
    parameter int XLEN = 32
) (
    input logic           clk,
    input logic           rst,
    execute_cycle_if.slave ex
);
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] fwdb;
    logic [XLEN-1:0] srcb;
    logic [XLEN-1:0] alu_res;
    logic            zero;

    // operand A: 10 takes last cycle's latched ALU result
    always_comb begin
        srca = ex.rd1_e;
        unique case (ex.forwarda_e)
            FWD_WB:  srca = ex.resultw;
            FWD_MEM: srca = ex.aluresultm;
            default: srca = ex.rd1_e;
        endcase
    end

    // operand B before the immediate mux; also the store data
    always_comb begin
        fwdb = ex.rd2_e;
        unique case (ex.forwardb_e)
            FWD_WB:  fwdb = ex.resultw;
            FWD_MEM: fwdb = ex.aluresultm;
            default: fwdb = ex.rd2_e;
        endcase
    end

    assign srcb = ex.alusrce ? ex.imm_ext_e : fwdb;

    // ALU; unused codes yield zero
    always_comb begin
        alu_res = '0;
        unique case (ex.alucontrole)
            ALU_ADD: alu_res = srca + srcb;
            ALU_SUB: alu_res = srca - srcb;
            ALU_AND: alu_res = srca & srcb;
            ALU_OR:  alu_res = srca | srcb;
            ALU_SLT: alu_res[0] = $signed(srca) < $signed(srcb);
            default: alu_res = '0;
        endcase
    end

    assign zero         = (alu_res == '0);
    assign ex.pcsrce    = ex.branche & zero;
    assign ex.pctargete = ex.pce + ex.imm_ext_e;

    // EX/MEM register, loaded every cycle, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex.regwritem  <= 1'b0;
            ex.memwritem  <= 1'b0;
            ex.resultsrcm <= 1'b0;
            ex.rd_m       <= '0;
            ex.pcplus4m   <= '0;
            ex.writedatam <= '0;
            ex.aluresultm <= '0;
        end else begin
            ex.regwritem  <= ex.regwritee;
            ex.memwritem  <= ex.memwritee;
            ex.resultsrcm <= ex.resultsrce;
            ex.rd_m       <= ex.rd_e;
            ex.pcplus4m   <= ex.pcplus4e;
            ex.writedatam <= fwdb;
            ex.aluresultm <= alu_res;
        end
    end
endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: directed literal cases plus
// randomized traffic against a behavioural model.
module tb_execute_cycle;
    logic clk;
    logic rst;

    execute_cycle_if #(.XLEN(32)) ex_if ();

    execute_cycle #(.XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .ex (ex_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    // model of the EX/MEM register contents
    logic        m_rw, m_mw, m_rs;
    logic [4:0]  m_rd;
    logic [31:0] m_pc4, m_wd, m_alu;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] alu_op(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel,
                                         input logic [31:0] base,
                                         input logic [31:0] wb,
                                         input logic [31:0] mem);
        if (sel == 2'b01) return wb;
        if (sel == 2'b10) return mem;
        return base;
    endfunction

    task automatic model_clear();
        m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0;
        m_pc4 = 0; m_wd = 0; m_alu = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".regwritem"}, {31'b0, ex_if.regwritem}, {31'b0, m_rw});
        chk({tag, ".memwritem"}, {31'b0, ex_if.memwritem}, {31'b0, m_mw});
        chk({tag, ".resultsrcm"}, {31'b0, ex_if.resultsrcm}, {31'b0, m_rs});
        chk({tag, ".rd_m"}, {27'b0, ex_if.rd_m}, {27'b0, m_rd});
        chk({tag, ".pcplus4m"}, ex_if.pcplus4m, m_pc4);
        chk({tag, ".writedatam"}, ex_if.writedatam, m_wd);
        chk({tag, ".aluresultm"}, ex_if.aluresultm, m_alu);
    endtask

    task automatic clear_inputs();
        ex_if.regwritee = 0; ex_if.alusrce = 0;
        ex_if.memwritee = 0; ex_if.resultsrce = 0;
        ex_if.branche = 0; ex_if.alucontrole = 0;
        ex_if.rd1_e = 0; ex_if.rd2_e = 0; ex_if.imm_ext_e = 0;
        ex_if.rd_e = 0; ex_if.pce = 0; ex_if.pcplus4e = 0;
        ex_if.resultw = 0; ex_if.forwarda_e = 0; ex_if.forwardb_e = 0;
    endtask

    task automatic rand_inputs();
        ex_if.regwritee = 1'($urandom);
        ex_if.alusrce = 1'($urandom);
        ex_if.memwritee = 1'($urandom);
        ex_if.resultsrce = 1'($urandom);
        ex_if.branche = 1'($urandom);
        ex_if.alucontrole = 3'($urandom);
        ex_if.rd1_e = $urandom;
        ex_if.rd2_e = $urandom;
        ex_if.imm_ext_e = $urandom;
        ex_if.rd_e = 5'($urandom);
        ex_if.pce = $urandom;
        ex_if.pcplus4e = $urandom;
        ex_if.resultw = $urandom;
        ex_if.forwarda_e = 2'($urandom);
        ex_if.forwardb_e = 2'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            ex_if.alucontrole = 3'd1;
            ex_if.alusrce = 0;
            ex_if.forwarda_e = 0;
            ex_if.forwardb_e = 0;
            ex_if.rd2_e = ex_if.rd1_e;
        end
    endtask

    // inputs are set just after a negedge; check comb, clock, check regs
    task automatic step(input string tag);
        logic [31:0] a, fb, b, r;
        #1;
        a  = pick(ex_if.forwarda_e, ex_if.rd1_e, ex_if.resultw, m_alu);
        fb = pick(ex_if.forwardb_e, ex_if.rd2_e, ex_if.resultw, m_alu);
        b  = ex_if.alusrce ? ex_if.imm_ext_e : fb;
        r  = alu_op(ex_if.alucontrole, a, b);
        chk({tag, ".pcsrce"}, {31'b0, ex_if.pcsrce},
            {31'b0, ex_if.branche && (r == 0)});
        chk({tag, ".pctargete"}, ex_if.pctargete,
            ex_if.pce + ex_if.imm_ext_e);
        @(posedge clk);
        m_rw = ex_if.regwritee; m_mw = ex_if.memwritee;
        m_rs = ex_if.resultsrce; m_rd = ex_if.rd_e;
        m_pc4 = ex_if.pcplus4e; m_wd = fb; m_alu = r;
        #1;
        check_regs(tag);
        @(negedge clk);
    endtask

    // async reset pulse between edges, clear of regs checked before next edge
    task automatic reset_pulse(input string tag);
        #1 rst = 1;
        #1;
        model_clear();
        check_regs(tag);
        #1 rst = 0;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        model_clear();
        clear_inputs();
        rst = 1;
        @(negedge clk);
        check_regs("reset");
        rst = 0;
        step("idle");

        // reset mid-stream with aluresultm = 1234
        ex_if.rd1_e = 32'h1200; ex_if.rd2_e = 32'h34;
        ex_if.regwritee = 1; ex_if.rd_e = 5'd9;
        ex_if.pcplus4e = 32'h44;
        step("pre_rst");
        chk("pre_rst.lit", ex_if.aluresultm, 32'h1234);
        reset_pulse("mid_rst");
        chk("mid_rst.alu_lit", ex_if.aluresultm, 32'h0);

        // add 5 + 7, first edge after release
        clear_inputs();
        ex_if.rd1_e = 5; ex_if.rd2_e = 7; ex_if.rd_e = 3;
        ex_if.regwritee = 1;
        step("add");
        chk("add.alu_lit", ex_if.aluresultm, 32'd12);
        chk("add.rd_lit", {27'b0, ex_if.rd_m}, 32'd3);
        chk("add.rw_lit", {31'b0, ex_if.regwritem}, 32'd1);
        chk("add.wd_lit", ex_if.writedatam, 32'd7);

        // forward previous ALU result into A
        clear_inputs();
        ex_if.forwarda_e = 2'b10; ex_if.imm_ext_e = 1;
        ex_if.alusrce = 1;
        step("fwd_mem");
        chk("fwd_mem.lit", ex_if.aluresultm, 32'd13);

        // store with writeback forwarding on B
        clear_inputs();
        ex_if.forwardb_e = 2'b01; ex_if.resultw = 32'hAA;
        ex_if.memwritee = 1; ex_if.alusrce = 1;
        ex_if.rd2_e = 32'h55; ex_if.imm_ext_e = 4;
        step("store");
        chk("store.wd_lit", ex_if.writedatam, 32'hAA);

        // slt signed
        clear_inputs();
        ex_if.rd1_e = 32'hFFFF_FFFF; ex_if.rd2_e = 1;
        ex_if.alucontrole = 3'b101;
        step("slt");
        chk("slt.lit", ex_if.aluresultm, 32'd1);

        // sub wraps
        clear_inputs();
        ex_if.rd1_e = 0; ex_if.rd2_e = 1; ex_if.alucontrole = 3'b001;
        step("sub");
        chk("sub.lit", ex_if.aluresultm, 32'hFFFF_FFFF);

        // beq taken, negative offset
        clear_inputs();
        ex_if.branche = 1; ex_if.alucontrole = 3'b001;
        ex_if.rd1_e = 9; ex_if.rd2_e = 9;
        ex_if.pce = 32'h100; ex_if.imm_ext_e = 32'hFFFF_FFF8;
        #1;
        chk("beq.pcsrce_lit", {31'b0, ex_if.pcsrce}, 32'd1);
        chk("beq.target_lit", ex_if.pctargete, 32'hF8);
        ex_if.rd2_e = 8;
        #1;
        chk("bne.pcsrce_lit", {31'b0, ex_if.pcsrce}, 32'd0);
        step("beq");

        // unused ALU code, target wrap
        clear_inputs();
        ex_if.alucontrole = 3'b110; ex_if.rd1_e = 3; ex_if.rd2_e = 4;
        ex_if.pce = 32'hFFFF_FFFC; ex_if.imm_ext_e = 8;
        #1;
        chk("wrap.target_lit", ex_if.pctargete, 32'h4);
        step("unused");
        chk("unused.lit", ex_if.aluresultm, 32'h0);

        // randomized traffic with occasional async reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 50) == 0) reset_pulse("rnd_rst");
            rand_inputs();
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute stage of the 5-stage pipelined RV32 core. It consumes the ID/EX pipeline outputs from the decode stage.
- Contains the operand forwarding muxes, the ALU, branch resolution and branch-target calculation.
- Registers all results into the EX/MEM pipeline register that feeds the memory stage.
- Drives branch redirect (pcsrce, pctargete) back to fetch combinationally in the same cycle.

Parameters:
- XLEN, 32, datapath width (only 32 is supported).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- regwritee  in  1  register-write control for the instruction in EX.
- alusrce  in  1  ALU B select: 0 = forwarded rs2 value, 1 = imm_ext_e.
- memwritee  in  1  store control.
- resultsrce  in  1  writeback select (0 = ALU, 1 = memory); passed through to MEM.
- branche  in  1  the instruction is a beq.
- alucontrole  in  3  ALU operation code.
- rd1_e  in  32  rs1 value read in decode.
- rd2_e  in  32  rs2 value read in decode.
- imm_ext_e  in  32  sign-extended immediate.
- rd_e  in  5  destination register.
- pce  in  32  PC of the instruction in EX.
- pcplus4e  in  32  PC + 4.
- resultw  in  32  writeback-stage result, used for forwarding.
- forwarda_e  in  2  forwarding select for operand A (driven by the hazard unit).
- forwardb_e  in  2  forwarding select for operand B.
- pcsrce  out  1  branch taken; combinational.
- pctargete  out  32  branch target; combinational.
- regwritem  out  1  registered regwritee.
- memwritem  out  1  registered memwritee.
- resultsrcm  out  1  registered resultsrce.
- rd_m  out  5  registered rd_e.
- pcplus4m  out  32  registered pcplus4e.
- writedatam  out  32  registered forwarded rs2 value (store data).
- aluresultm  out  32  registered ALU result.

Behaviour:
- Forward mux A selects srca from forwarda_e:
  - 00: rd1_e
  - 01: resultw
  - 10: aluresultm (current register value)
  - 11: rd1_e
- Forward mux B selects fwdb from forwardb_e using the same encoding, with rd2_e as the 00/11 source.
- srcb = imm_ext_e when alusrce=1, otherwise fwdb.
- ALU, all arithmetic modulo 2^32, overflow ignored:
  - 000: add
  - 001: sub (srca - srcb)
  - 010: and
  - 011: or
  - 101: slt, signed compare; result is 32'h1 or 32'h0
  - 100, 110, 111: result 32'h0
- zero = (alu result == 0).
- pcsrce = branche & zero. This is combinational from the current EX inputs.
- pctargete = pce + imm_ext_e, modulo 2^32, wrapping. It is always computed, independent of branche.
- EX/MEM register: on each rising clk edge (rst low), latch the following, unconditionally every cycle:
  - regwritem ← regwritee, memwritem ← memwritee, resultsrcm ← resultsrce
  - rd_m ← rd_e, pcplus4m ← pcplus4e
  - writedatam ← fwdb (the forwarded value, never the immediate)
  - aluresultm ← ALU result
- Latency: 1 cycle from EX inputs to the *m outputs.
- No stall or enable input; flushing is done upstream by zeroing the control inputs.
- Forwarding select 10 uses the previous cycle's latched aluresultm, so back-to-back dependent ALU ops resolve with zero bubbles.
- Reset: when rst is asserted (asynchronously, including mid-operation), all registered outputs go to 0 immediately:
  - regwritem=0, memwritem=0, resultsrcm=0, rd_m=5'h00
  - pcplus4m=0, writedatam=0, aluresultm=0
- Combinational outputs during reset follow the inputs; with forwarding select 10 they see aluresultm=0.
- Release of rst: the first edge after deassertion latches the current inputs.

Test Plan:
- Apply rst mid-stream while aluresultm=32'h1234 → every *m output reads 0 before the next clk edge; first edge after release latches normally.
- Add: alucontrole=000, alusrce=0, rd1_e=5, rd2_e=7, rd_e=3, regwritee=1 → next edge: aluresultm=12, rd_m=3, regwritem=1, writedatam=7.
- Forwarding: cycle 1 add produces aluresultm=12; cycle 2 with forwarda_e=10, rd1_e=0, imm_ext_e=1, alusrce=1 → aluresultm=13. With forwardb_e=01, resultw=32'hAA, and a store (memwritee=1, alusrce=1) → writedatam=32'hAA.
- slt signed: rd1_e=32'hFFFFFFFF, rd2_e=1, alucontrole=101 → aluresultm=1. Sub wrap: 0 - 1 → 32'hFFFFFFFF.
- beq: branche=1, alucontrole=001, rd1_e=rd2_e=9, pce=32'h100, imm_ext_e=32'hFFFFFFF8 → pcsrce=1 and pctargete=32'hF8, same cycle. With rd2_e=8 → pcsrce=0.
- Unused ALU code 110, plus pce=32'hFFFFFFFC, imm_ext_e=8 → aluresultm=0 and pctargete=32'h4 (wrap-around).
